// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction-memory fetch block.
//   state_e       : controller states (INIT clear sweep, RUN normal service)
//   FAULT_*       : fault-cause codes for a fetch request
//   NOP_INSTR     : instruction word returned for faults and written by the sweep
//   RSP_W         : width of one response entry ({fault, instr})
//   fault_cause() : classifies a fetch byte address against the memory size
package imem_fetch_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          RSP_W     = 33;

  // aw is log2 of the word count; any set bit above the word index means the
  // word index is >= DEPTH. Misalignment takes priority when both apply.
  function automatic logic [1:0] fault_cause(input logic [31:0] addr,
                                             input int unsigned aw);
    if (addr[1:0] != 2'b00)
      return FAULT_MISALIGN;
    if ((addr >> (aw + 32'd2)) != 32'd0)
      return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Two-entry response FIFO for the fetch block.
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   flush       : synchronous discard of all entries
//   push, push_data : enqueue one response entry
//   pop         : dequeue the head entry
//   head        : current head entry (meaningful only when !empty)
//   empty       : no entries held
//   count       : number of entries held (0..2)
module fetch_rsp_fifo
  import imem_fetch_pkg::*;
#(
  parameter int WIDTH = RSP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against over/underflow; a full FIFO may still accept a push when
  // the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        entry_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop)
        rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = entry_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a program-load port and a pipelined fetch port.
//   clk, reset       : clock, asynchronous active-high reset
//   prog_we/addr/data: program-load write (ignored during the clear sweep)
//   req_valid/ready  : fetch request handshake, req_addr is the byte PC
//   rsp_valid/ready  : response handshake, rsp_instr/rsp_fault the payload
//   flush            : drops the in-flight read and every queued response
//   init_busy        : high while the clear sweep runs
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | zeroing words 0..DEPTH-1, one per cycle; no fetches or loads
// RUN   | serving fetches and program loads
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_fault,
  input  logic                     flush,
  output logic                     init_busy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // Holds req_ready low until the first edge after reset, so the port stays
  // closed throughout reset even when no sweep is configured.
  logic          rdy_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? INIT : RUN;
      clr_cnt_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    init_busy = 1'b0;
    case (state_q)
      INIT: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = NOP_INSTR;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1))
          state_d = RUN;
      end
      RUN: begin
        mem_we = prog_we;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Fetch side: one registered read stage (in-flight) feeding a 2-entry FIFO.
  logic [1:0]       req_cause;
  logic             req_bad;
  logic [AW-1:0]    req_idx;
  logic             accept;
  logic             inflight_v_q;
  logic [RSP_W-1:0] inflight_q;
  logic             fifo_push;
  logic             fifo_pop;
  logic [RSP_W-1:0] fifo_head;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  logic [1:0]       occupancy;
  logic [RSP_W-1:0] rsp_entry;

  assign req_cause = fault_cause(req_addr, AW);
  assign req_bad   = (req_cause != FAULT_NONE);
  assign req_idx   = req_addr[AW+1:2];

  assign occupancy = fifo_count + {1'b0, inflight_v_q};
  assign req_ready = rdy_en_q && (state_q == RUN) && !flush && (occupancy < 2'd2);
  assign accept    = req_valid && req_ready;

  // The memory read happens in the accept edge, so the old word is returned
  // when a program load hits the same word in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_v_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      inflight_v_q <= accept;
      if (accept)
        inflight_q <= req_bad ? {1'b1, NOP_INSTR} : {1'b0, mem[req_idx]};
    end
  end

  // A fresh read bypasses the FIFO when nothing is queued and the consumer
  // takes it straight away; otherwise it is parked in the FIFO.
  assign fifo_pop  = !fifo_empty && rsp_ready;
  assign fifo_push = inflight_v_q && !(fifo_empty && rsp_ready);

  fetch_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (inflight_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_entry = fifo_empty ? inflight_q : fifo_head;
  assign rsp_valid = inflight_v_q || !fifo_empty;
  assign rsp_fault = rsp_entry[32];
  assign rsp_instr = rsp_entry[31:0];

endmodule
